// File: rtl/pong_pkg.sv
// Shared types and constants for the paddle-game ball logic.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    PLAY = 2'd2
  } ball_state_e;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } x_dir_e;

  localparam int VEL_W        = 6;
  localparam int MISS_COUNT_W = 4;

  typedef logic signed [VEL_W-1:0] vel_t;

endpackage

// File: rtl/ball_axis_clamp.sv
// One-axis position step with wall clamping. The sum is formed two bits
// wider than the position so a step below zero stays negative and is
// caught by the lower limit instead of wrapping.
module ball_axis_clamp #(
  parameter int W = 10
) (
  input  logic [W-1:0]        pos,
  input  logic signed [W+1:0] step,
  input  logic [W-1:0]        lo,
  input  logic [W-1:0]        hi,
  output logic [W-1:0]        next_pos,
  output logic                hit_lo,
  output logic                hit_hi
);

  logic signed [W+1:0] sum;

  assign sum = signed'({2'b00, pos}) + step;

  // Clamp the stepped position into [lo, hi] and flag which side was hit.
  always_comb begin
    hit_lo   = 1'b0;
    hit_hi   = 1'b0;
    next_pos = sum[W-1:0];
    if (sum < signed'({2'b00, lo})) begin
      hit_lo   = 1'b1;
      next_pos = lo;
    end else if (sum > signed'({2'b00, hi})) begin
      hit_hi   = 1'b1;
      next_pos = hi;
    end
  end

endmodule

// File: rtl/ball_motion.sv
// Ball kinematics: serve/hold/play sequencing, per-frame motion, wall and
// ceiling reflection, floor clamp, hit/miss reporting.
// Optional feature macro: BALL_GRAVITY_EN (vy decays by 1 per PLAY tick).
//
// state | meaning
// IDLE  | ball parked at serve point, waiting for serve
// HOLD  | counting frame ticks before launch
// PLAY  | ball moving, paddle/floor contact evaluated each tick
module ball_motion import pong_pkg::*; #(
  parameter int BIT_WIDTH    = 10,
  parameter int BALL_RADIUS  = 4,
  parameter int MID_X        = 320,
  parameter int SERVE_Y      = 240,
  parameter int FLOOR_Y      = 8,
  parameter int X_MAX        = 639,
  parameter int Y_MAX        = 479,
  parameter int VEL_WIDTH    = 6,
  parameter int SERVE_VY     = 3,
  parameter int SERVE_FRAMES = 60
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_tick,
  input  logic                    serve,
  input  logic                    touchingPaddle,
  input  logic                    touchingFloor,
  output logic [BIT_WIDTH-1:0]    ballX,
  output logic [BIT_WIDTH-1:0]    ballY,
  output logic                    ball_active,
  output logic                    hit_pulse,
  output logic                    miss_pulse,
  output logic [MISS_COUNT_W-1:0] miss_count
);

  localparam int EW    = BIT_WIDTH + 2;
  localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

  localparam logic [BIT_WIDTH-1:0] X_LO = BIT_WIDTH'(BALL_RADIUS);
  localparam logic [BIT_WIDTH-1:0] X_HI = BIT_WIDTH'(X_MAX - BALL_RADIUS);
  localparam logic [BIT_WIDTH-1:0] Y_LO = BIT_WIDTH'(FLOOR_Y + BALL_RADIUS);
  localparam logic [BIT_WIDTH-1:0] Y_HI = BIT_WIDTH'(Y_MAX - BALL_RADIUS);
  localparam logic [BIT_WIDTH-1:0] PARK_X = BIT_WIDTH'(MID_X);
  localparam logic [BIT_WIDTH-1:0] PARK_Y = BIT_WIDTH'(SERVE_Y);
  localparam logic [CNT_W-1:0]     HOLD_LAST = CNT_W'(SERVE_FRAMES - 1);

  ball_state_e                 state;
  x_dir_e                      x_dir;
  logic signed [VEL_WIDTH-1:0] vy;
  logic [CNT_W-1:0]            hold_cnt;

  x_dir_e                      dir_eff;
  x_dir_e                      dir_move;
  logic signed [EW-1:0]        x_step;
  logic signed [EW-1:0]        y_step;
  logic [BIT_WIDTH-1:0]        x_next;
  logic [BIT_WIDTH-1:0]        y_next;
  logic                        x_lo;
  logic                        x_hi;
  logic                        unused_y_lo;
  logic                        y_hi;
  logic signed [VEL_WIDTH-1:0] vy_after;
  logic signed [VEL_WIDTH-1:0] vy_play;

  // A paddle hit flips direction before the step of the same tick.
  assign dir_eff = touchingPaddle ? ((x_dir == LEFT) ? RIGHT : LEFT) : x_dir;
  assign x_step  = (dir_eff == RIGHT) ? {{(EW-1){1'b0}}, 1'b1} : {EW{1'b1}};
  assign y_step  = {{(EW-VEL_WIDTH){vy[VEL_WIDTH-1]}}, vy};

  ball_axis_clamp #(.W(BIT_WIDTH)) u_clamp_x (
    .pos      (ballX),
    .step     (x_step),
    .lo       (X_LO),
    .hi       (X_HI),
    .next_pos (x_next),
    .hit_lo   (x_lo),
    .hit_hi   (x_hi)
  );

  // The floor clamp only pins Y; its flag is not needed here because the
  // collision stage reports floor contact on the following tick.
  ball_axis_clamp #(.W(BIT_WIDTH)) u_clamp_y (
    .pos      (ballY),
    .step     (y_step),
    .lo       (Y_LO),
    .hi       (Y_HI),
    .next_pos (y_next),
    .hit_lo   (unused_y_lo),
    .hit_hi   (y_hi)
  );

  // Wall contact forces direction away from the wall; ceiling forces vy down.
  assign dir_move = x_lo ? RIGHT : (x_hi ? LEFT : dir_eff);
  assign vy_after = y_hi ? (vy[VEL_WIDTH-1] ? vy : -vy) : vy;

`ifdef BALL_GRAVITY_EN
  localparam logic signed [VEL_WIDTH-1:0] VY_MIN = {1'b1, {(VEL_WIDTH-1){1'b0}}};
  // Gravity pulls vy down by one per tick, stopping at the most negative value.
  assign vy_play = (vy_after == VY_MIN) ? vy_after : vy_after - VEL_WIDTH'(1);
`else
  assign vy_play = vy_after;
`endif

  // Sequencer plus registered position, velocity and reporting outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      x_dir       <= LEFT;
      vy          <= '0;
      hold_cnt    <= '0;
      ballX       <= PARK_X;
      ballY       <= PARK_Y;
      ball_active <= 1'b0;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
      miss_count  <= '0;
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (serve) begin
            state    <= HOLD;
            hold_cnt <= '0;
          end
        end
        HOLD: begin
          if (frame_tick) begin
            if (hold_cnt == HOLD_LAST) begin
              state       <= PLAY;
              x_dir       <= LEFT;
              vy          <= VEL_WIDTH'(SERVE_VY);
              ball_active <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + CNT_W'(1);
            end
          end
        end
        PLAY: begin
          if (frame_tick) begin
            if (!touchingPaddle && touchingFloor) begin
              miss_pulse  <= 1'b1;
              if (miss_count != '1) miss_count <= miss_count + MISS_COUNT_W'(1);
              state       <= IDLE;
              ball_active <= 1'b0;
              ballX       <= PARK_X;
              ballY       <= PARK_Y;
              x_dir       <= LEFT;
              vy          <= '0;
            end else begin
              hit_pulse <= touchingPaddle;
              ballX     <= x_next;
              ballY     <= y_next;
              x_dir     <= dir_move;
              vy        <= vy_play;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ball_motion.md
# ball_motion

Frame-rate ball kinematics engine for the paddle game. Holds the ball's position and velocity, advances them once per frame tick, and reflects off the arena walls and the ceiling. Consumes the `touchingPaddle` / `touchingFloor` flags from the collision stage, which are computed combinationally from this block's own `ballX` / `ballY` outputs. Runs the serve / play / miss sequence and reports hits and misses to the score logic.

## Interface
- `BIT_WIDTH`, 10: coordinate width; unsigned, Y increases upward.
- `BALL_RADIUS`, 4: ball half-size in pixels.
- `MID_X`, 320: serve X position.
- `SERVE_Y`, 240: serve Y position.
- `FLOOR_Y`, 8: floor line; must match the collision stage.
- `X_MAX`, 639: right arena edge.
- `Y_MAX`, 479: ceiling.
- `VEL_WIDTH`, 6: signed vertical-velocity width.
- `SERVE_VY`, 3: initial vertical velocity; signed, must be positive.
- `SERVE_FRAMES`, 60: frame ticks the ball holds before launch.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `serve` in 1: launch request; level or pulse.
- `touchingPaddle` in 1: paddle contact flag from the collision stage.
- `touchingFloor` in 1: floor contact flag from the collision stage.
- `ballX` out BIT_WIDTH: ball centre X.
- `ballY` out BIT_WIDTH: ball centre Y.
- `ball_active` out 1: high while in PLAY.
- `hit_pulse` out 1: one cycle per paddle bounce.
- `miss_pulse` out 1: one cycle per floor hit.
- `miss_count` out 4: saturating count of misses.

## Operation
- States: IDLE, HOLD, PLAY.
- **IDLE:** ball parked at (`MID_X`, `SERVE_Y`). `serve` high → HOLD with the hold counter cleared.
- **HOLD:** the counter increments on each `frame_tick`. When the counter reaches `SERVE_FRAMES`-1 on a tick, the block loads `x_dir`=left (X decreasing) and `vy`=`SERVE_VY`, then enters PLAY.
- **PLAY**, evaluated on each `frame_tick` in this priority order:
  1. `touchingPaddle`: flip `x_dir` and pulse `hit_pulse`. The X step in the same tick uses the new direction.
  2. `touchingFloor` (with no paddle contact): pulse `miss_pulse`, increment `miss_count` (saturating at 15), return to IDLE and re-park the ball. No move is applied.
  3. Otherwise, move: X ±1 per tick; Y += `vy`.
- X step is fixed at magnitude 1 because paddle detection is an equality compare. Wall reflection:
  - If X would drop below `BALL_RADIUS`, set X to `BALL_RADIUS` and direction to right.
  - If X would exceed `X_MAX`-`BALL_RADIUS`, set X to that limit and direction to left.
- Y clamps:
  - If Y would exceed `Y_MAX`-`BALL_RADIUS`, set Y to that limit and `vy` to -|`vy`|.
  - If Y would drop below `FLOOR_Y`+`BALL_RADIUS`, set Y to exactly that value so the collision stage sees equality on the next tick. This prevents tunnelling through the floor.
- Arithmetic:
  - Positions are zero-extended by 2 bits.
  - `vy` is sign-extended to BIT_WIDTH+2 and added.
  - Clamp comparisons are made at the extended width, so intermediate negatives never wrap.
- `serve` is ignored in HOLD and PLAY.

## Timing
- All outputs are registered. State and position update on the `clk` edge that samples `frame_tick`=1, and are visible the following cycle.
- The touching flags are sampled only on `frame_tick` cycles; they are ignored otherwise.
- `hit_pulse` and `miss_pulse` are high for exactly the one cycle after the qualifying tick.
- Reset values:
  - State IDLE.
  - `ballX`=`MID_X`, `ballY`=`SERVE_Y`.
  - `vy`=0, `x_dir`=left.
  - `ball_active`=0, `hit_pulse`=0, `miss_pulse`=0, `miss_count`=0.
- Reset asserted mid-PLAY or mid-HOLD: outputs return to reset values immediately (asynchronous), and no pulse is emitted.
- Simultaneous paddle and floor contact: paddle wins and the ball is saved.

## Configuration
- `BALL_GRAVITY_EN` defined: in PLAY, every `frame_tick` also applies `vy` -= 1 after the position update, saturating at -(2^(VEL_WIDTH-1)).
- `BALL_GRAVITY_EN` undefined: `vy` changes only at ceiling reflection and at serve, giving straight-line motion.

## Structure
- `pong_pkg` holds:
  - the `ball_state_e` enum (IDLE, HOLD, PLAY);
  - the `x_dir_e` enum (LEFT, RIGHT);
  - the signed `vel_t` typedef;
  - `MISS_COUNT_W`=4.
- One sub-module, `ball_axis_clamp`: purely combinational. It takes a position, a signed step and lower/upper limits, and returns the clamped next position plus `hit_lo` / `hit_hi` flags. It is instantiated twice, once for X and once for Y.

## Test plan
- Reset, then `serve`=1, then 60 ticks → PLAY entered on tick 60; `ballX`=319 and `ballY`=243 after the first PLAY tick.
- In PLAY at X=100, assert `touchingPaddle` on a tick → `hit_pulse` for 1 cycle; `ballX`=101 next.
- Ball at Y=13 with `vy`=-3 (gravity off) → `ballY`=12 (clamped); then `touchingFloor` on the next tick → `miss_pulse`, `miss_count`=1, state IDLE, ball at (320, 240).
- `touchingPaddle` and `touchingFloor` both high on the same tick → `hit_pulse` only; `miss_count` unchanged.
- Ball at Y=474 with `vy`=+3 → `ballY`=475 and `vy`=-3; ball at X=4 moving left → X=4, direction right.
- Assert `rst_n` low mid-PLAY → all outputs at reset values within the same cycle. Separately, 16 misses → `miss_count` holds at 15.
